// File: rtl/int_pkg.sv
// ---------------------------------------------------------------------------
// int_pkg
// Shared definitions for the interrupt controller:
//   state_e         - controller FSM encoding (IDLE / SERVE / FIN)
//   MCAUSE_INT_BIT  - interrupt flag position in mcause
//   CAUSE_W         - width of the exception-code field driven by this block
//   make_mcause()   - builds a full mcause word from an exception code
// ---------------------------------------------------------------------------
package int_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SERVE = 2'd1,
    FIN   = 2'd2
  } state_e;

  localparam int MCAUSE_INT_BIT = 31;
  localparam int CAUSE_W        = 5;

  function automatic logic [31:0] make_mcause(input logic [CAUSE_W-1:0] code);
    logic [31:0] v;
    v                 = '0;
    v[MCAUSE_INT_BIT] = 1'b1;
    v[CAUSE_W-1:0]    = code;
    return v;
  endfunction

endpackage

// File: rtl/int_prio_enc.sv
// ---------------------------------------------------------------------------
// int_prio_enc
// Combinational lowest-index-wins priority encoder.
// Ports:
//   i_vec   [N_SRC-1:0]  request vector
//   o_idx   [IDX_W-1:0]  index of the lowest set bit (0 when none set)
//   o_valid              at least one bit of i_vec is set
// ---------------------------------------------------------------------------
module int_prio_enc #(
  parameter int N_SRC = 16,
  parameter int IDX_W = (N_SRC > 1) ? $clog2(N_SRC) : 1
) (
  input  logic [N_SRC-1:0] i_vec,
  output logic [IDX_W-1:0] o_idx,
  output logic             o_valid
);

  // Scanning from the top down lets the lowest set index overwrite any
  // higher one, so the final value is the highest-priority source.
  always_comb begin
    // NOTE: every always_comb output gets a default before any conditional
    // assignment; a path that leaves it unassigned would infer a latch.
    o_idx = '0;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (i_vec[i]) o_idx = IDX_W'(i);
    end
  end

  assign o_valid = |i_vec;

endmodule

// File: rtl/interrupt_controller.sv
// ---------------------------------------------------------------------------
// interrupt_controller
// Collects level interrupt requests, masks them with mie, serves one source at
// a time by fixed priority (lowest index first) and hands a one-cycle
// completion pulse back to the served peripheral when the core executes mret.
// Ports:
//   clk        system clock, rising edge
//   reset      asynchronous active-low reset
//   int_req_i  [N_SRC]  level requests from peripherals
//   mie_i      [N_SRC]  per-source enables from the mie CSR
//   int_rst_i           core pulse: current handler finished
//   int_o               registered interrupt request to the core
//   mcause_o   [32]     registered cause for int_o
//   int_fin_o  [N_SRC]  registered one-hot completion pulse to the served source
// ---------------------------------------------------------------------------
module interrupt_controller
  import int_pkg::*;
#(
  parameter int N_SRC      = 16,
  parameter int CAUSE_BASE = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_SRC-1:0] int_req_i,
  input  logic [N_SRC-1:0] mie_i,
  input  logic             int_rst_i,
  output logic             int_o,
  output logic [31:0]      mcause_o,
  output logic [N_SRC-1:0] int_fin_o
);

  localparam int IDX_W = (N_SRC > 1) ? $clog2(N_SRC) : 1;

  // Every source must map onto a 5-bit exception code.
  if (N_SRC < 1 || N_SRC > 27) begin : g_bad_nsrc
    $error("interrupt_controller: N_SRC must be in 1..27");
  end
  if (CAUSE_BASE < 0 || CAUSE_BASE + N_SRC - 1 > 31) begin : g_bad_cause
    $error("interrupt_controller: CAUSE_BASE+N_SRC-1 exceeds 31");
  end

  state_e             r_state, w_state_next;
  logic [IDX_W-1:0]   r_idx, w_idx_next;
  logic               r_int, w_int_next;
  logic [31:0]        r_mcause, w_mcause_next;
  logic [N_SRC-1:0]   r_fin, w_fin_next;

  logic [N_SRC-1:0]   w_pend;
  logic [IDX_W-1:0]   w_sel;
  logic               w_valid;
  logic [CAUSE_W-1:0] w_code;

  assign w_pend = int_req_i & mie_i;

  int_prio_enc #(
    .N_SRC (N_SRC),
    .IDX_W (IDX_W)
  ) u_prio_enc (
    .i_vec   (w_pend),
    .o_idx   (w_sel),
    .o_valid (w_valid)
  );

  // 5-bit modular add; the elaboration check above keeps it from wrapping.
  assign w_code = CAUSE_W'(CAUSE_BASE) + CAUSE_W'(w_sel);

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples the pre-edge values regardless of statement order.
      r_state <= w_state_next;
    end
  end

  // Next-state logic. In SERVE the request/mask inputs are deliberately not
  // looked at: the core has already committed to this source.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (w_valid)   w_state_next = SERVE;
      SERVE:   if (int_rst_i) w_state_next = FIN;
      FIN:                    w_state_next = IDLE;
      default:                w_state_next = IDLE;
    endcase
  end

  // Output logic: next values of the registered outputs and latched index.
  always_comb begin
    w_idx_next    = r_idx;
    w_int_next    = r_int;
    w_mcause_next = r_mcause;
    w_fin_next    = '0;
    case (r_state)
      IDLE: begin
        w_int_next = w_valid;
        if (w_valid) begin
          w_idx_next    = w_sel;
          w_mcause_next = make_mcause(w_code);
        end
      end
      SERVE: begin
        if (int_rst_i) begin
          w_int_next = 1'b0;
          w_fin_next = N_SRC'(1) << r_idx;
        end
      end
      // FIN holds the pulse for one cycle only; the default clears it so the
      // source gets one edge to drop its level before IDLE samples again.
      FIN:     w_int_next = 1'b0;
      default: w_int_next = 1'b0;
    endcase
  end

  // Output / index registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_idx    <= '0;
      r_int    <= 1'b0;
      r_mcause <= '0;
      r_fin    <= '0;
    end else begin
      r_idx    <= w_idx_next;
      r_int    <= w_int_next;
      r_mcause <= w_mcause_next;
      r_fin    <= w_fin_next;
    end
  end

  assign int_o     = r_int;
  assign mcause_o  = r_mcause;
  assign int_fin_o = r_fin;

endmodule

// File: tb/tb_interrupt_controller.sv
// ---------------------------------------------------------------------------
// tb_interrupt_controller
// Directed scenarios followed by a randomized phase, all compared every cycle
// against a transaction-level model of the controller (which source is being
// served, and whether its completion pulse is due).
// ---------------------------------------------------------------------------
module tb_interrupt_controller;

  localparam int N_SRC      = 16;
  localparam int CAUSE_BASE = 16;

  logic             clk = 1'b0;
  logic             reset;
  logic [N_SRC-1:0] int_req_i;
  logic [N_SRC-1:0] mie_i;
  logic             int_rst_i;
  logic             int_o;
  logic [31:0]      mcause_o;
  logic [N_SRC-1:0] int_fin_o;

  always #5 clk = ~clk;

  interrupt_controller #(
    .N_SRC      (N_SRC),
    .CAUSE_BASE (CAUSE_BASE)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .int_req_i (int_req_i),
    .mie_i     (mie_i),
    .int_rst_i (int_rst_i),
    .int_o     (int_o),
    .mcause_o  (mcause_o),
    .int_fin_o (int_fin_o)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: index being served (-1 = none) and a pending-done flag.
  int               m_serving;
  bit               m_done_cycle;
  logic             exp_int;
  logic [31:0]      exp_mcause;
  logic [N_SRC-1:0] exp_fin;

  // Keyboard peripheral on source 0.
  bit kb_mode;
  bit kb_int;

  function automatic int lowest_set(input logic [N_SRC-1:0] v);
    int i;
    i = 0;
    while (i < N_SRC && !v[i]) i++;
    return i;
  endfunction

  task automatic model_reset();
    m_serving    = -1;
    m_done_cycle = 1'b0;
    exp_int      = 1'b0;
    exp_mcause   = 32'h0;
    exp_fin      = '0;
  endtask

  // Advance the model across one rising edge using the current inputs.
  task automatic model_step();
    logic [N_SRC-1:0] pend;
    pend = int_req_i & mie_i;
    if (m_done_cycle) begin
      m_done_cycle = 1'b0;
      exp_fin      = '0;
    end else if (m_serving < 0) begin
      if (pend != '0) begin
        m_serving  = lowest_set(pend);
        exp_int    = 1'b1;
        exp_mcause = 32'h8000_0000 | 32'(CAUSE_BASE + m_serving);
      end
    end else if (int_rst_i) begin
      exp_fin      = '0;
      exp_fin[m_serving] = 1'b1;
      exp_int      = 1'b0;
      m_serving    = -1;
      m_done_cycle = 1'b1;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    assert (got === exp)
    else begin
      n_fail++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic check_outputs(input string tag);
    check({tag, ".int_o"},     32'(int_o),     32'(exp_int));
    check({tag, ".mcause_o"},  mcause_o,       exp_mcause);
    check({tag, ".int_fin_o"}, 32'(int_fin_o), 32'(exp_fin));
  endtask

  // One clock cycle: model update, edge, keyboard reaction, output check.
  task automatic tick(input string tag);
    logic [N_SRC-1:0] fin_seen;
    fin_seen = int_fin_o;
    model_step();
    @(posedge clk);
    if (kb_mode && fin_seen[0]) kb_int = 1'b0;
    #1;
    check_outputs(tag);
  endtask

  // Asynchronous reset applied away from any clock edge.
  task automatic do_reset();
    reset = 1'b0;
    model_reset();
    #1;
    check_outputs("async_reset");
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int core_cnt;
    int rises;
    logic prev_int;

    kb_mode   = 1'b0;
    kb_int    = 1'b0;
    int_req_i = '1;
    mie_i     = '1;
    int_rst_i = 1'b0;

    // Reset with every source requesting; release -> source 0 served.
    do_reset();
    tick("rst_release");
    check("rst_release.mcause_const", mcause_o, 32'h8000_0010);
    int_req_i = '0;
    int_rst_i = 1'b1;
    tick("drain_fin");
    int_rst_i = 1'b0;
    tick("drain_idle");

    // Single source.
    mie_i     = 16'h0008;
    int_req_i = 16'h0008;
    tick("single");
    check("single.mcause_const", mcause_o, 32'h8000_0013);
    int_rst_i = 1'b1;
    tick("single_fin");
    check("single_fin.fin_const", 32'(int_fin_o), 32'h0008);
    int_rst_i = 1'b0;
    int_req_i = '0;
    tick("single_after");
    check("single_after.fin_const", 32'(int_fin_o), 32'h0);

    // Priority: two simultaneous requests served in ascending order.
    mie_i     = 16'hFFFF;
    int_req_i = 16'h0024;
    tick("prio_first");
    check("prio_first.mcause_const", mcause_o, 32'h8000_0012);
    int_rst_i = 1'b1;
    tick("prio_first_fin");
    check("prio_first_fin.fin_const", 32'(int_fin_o), 32'h0004);
    int_rst_i = 1'b0;
    int_req_i = 16'h0020;
    tick("prio_fin_to_idle");
    tick("prio_second");
    check("prio_second.mcause_const", mcause_o, 32'h8000_0015);
    int_rst_i = 1'b1;
    tick("prio_second_fin");
    check("prio_second_fin.fin_const", 32'(int_fin_o), 32'h0020);
    int_rst_i = 1'b0;
    int_req_i = '0;
    tick("prio_done");

    // Masked request, then enable, then drop everything mid-serve.
    int_req_i = 16'h0001;
    mie_i     = 16'h0000;
    repeat (20) tick("masked");
    mie_i = 16'h0001;
    tick("unmasked");
    int_req_i = '0;
    mie_i     = '0;
    repeat (3) tick("held");
    check("held.int_const", 32'(int_o), 32'h1);
    int_rst_i = 1'b1;
    tick("held_fin");
    check("held_fin.fin_const", 32'(int_fin_o), 32'h0001);
    int_rst_i = 1'b0;
    tick("held_done");

    // Reset mid-SERVE: request still pending is re-served.
    int_req_i = 16'h0002;
    mie_i     = 16'hFFFF;
    tick("serve_pre_rst");
    tick("serve_pre_rst2");
    do_reset();
    tick("serve_reserve");
    check("serve_reserve.mcause_const", mcause_o, 32'h8000_0011);

    // Reset mid-FIN: pulse cleared at once and never reappears.
    int_rst_i = 1'b1;
    tick("fin_pre_rst");
    int_rst_i = 1'b0;
    do_reset();
    tick("fin_reserve");
    int_rst_i = 1'b1;
    tick("fin_reserve_fin");
    int_rst_i = 1'b0;
    int_req_i = '0;
    tick("fin_reserve_done");
    tick("fin_reserve_idle");

    // Keyboard loopback with a core that answers 5 cycles after int_o.
    do_reset();
    mie_i    = 16'h0001;
    kb_mode  = 1'b1;
    kb_int   = 1'b1;
    core_cnt = 0;
    rises    = 0;
    prev_int = 1'b0;
    for (int i = 0; i < 60; i++) begin
      if (i == 30) kb_int = 1'b1;
      int_req_i    = '0;
      int_req_i[0] = kb_int;
      int_rst_i    = (core_cnt == 5);
      tick("kb");
      if (int_o) core_cnt++;
      else       core_cnt = 0;
      if (int_o && !prev_int) rises++;
      prev_int = int_o;
    end
    check("kb.rises", 32'(rises), 32'd2);
    check("kb.level_dropped", 32'(kb_int), 32'd0);
    kb_mode   = 1'b0;
    int_rst_i = 1'b0;

    // Randomized phase.
    for (int i = 0; i < 1500; i++) begin
      int_req_i = N_SRC'($urandom);
      mie_i     = N_SRC'($urandom | $urandom);
      int_rst_i = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 199) == 0) do_reset();
      tick("rand");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/interrupt_controller.md
Name: interrupt_controller

Overview:
- Receiving end of the peripheral interrupt handshake. Peripherals such as keyboard hold a level request until they get a completion pulse on their int-reset input.
- Collects N_SRC level requests, masks them with the core's MIE vector, picks one by fixed priority and raises a single interrupt to the core with an mcause value.
- When the core signals handler completion (mret), returns a one-cycle completion pulse to the served source only.
- Sits between the peripheral bus devices and the core's CSR/trap unit.

Parameters:
N_SRC, 16, number of interrupt sources (1..27)
CAUSE_BASE, 16, mcause exception code for source 0; source i reports CAUSE_BASE+i

Ports:
clk  in  1  system clock, all state on rising edge
reset  in  1  asynchronous, active-low reset
int_req_i  in  N_SRC  level interrupt requests from peripherals (e.g. kb_int_o on bit 0)
mie_i  in  N_SRC  per-source enable from the mie CSR
int_rst_i  in  1  core pulse: current handler finished (mret)
int_o  out  1  interrupt request to core
mcause_o  out  32  cause of the request on int_o
int_fin_o  out  N_SRC  one-hot completion pulse to the served peripheral (drives kb_int_rst_i)

Behaviour:
- Reset (reset=0, async): state=IDLE, int_o=0, mcause_o=32'h0, int_fin_o=0, latched index=0. All outputs are registered.
- pend = int_req_i & mie_i. sel = lowest set index of pend.
- FSM, 3 states:
  - IDLE: if pend!=0, latch sel, then go to SERVE. int_o=1 and mcause_o={1'b1, 26'b0, 5'(CAUSE_BASE+sel)} are registered on that edge. Latency is 1 cycle from a sampled request to int_o.
  - SERVE: hold int_o and mcause_o. Ignore int_req_i and mie_i changes, including a request that drops or is masked; the core is already committed. On int_rst_i=1, go to FIN and register int_fin_o = 1<<idx, int_o=0, mcause_o unchanged.
  - FIN: exactly one cycle with int_fin_o high. Next edge: int_fin_o=0, go to IDLE. This gives the source one edge to drop its level, so IDLE does not re-sample a stale request.
- int_rst_i in IDLE or FIN is ignored. No fin pulse is generated.
- Simultaneous requests are served one at a time in ascending index order. The next one is taken in the first IDLE cycle after FIN.
- A source that keeps requesting after fin is served again. Back-to-back minimum spacing between int_o assertions is 3 cycles.
- CAUSE_BASE+sel is computed 5 bits wide. Elaboration fails (assertion) if CAUSE_BASE+N_SRC-1 > 31.
- Reset asserted mid-SERVE or mid-FIN clears everything immediately. No fin pulse is emitted, and peripherals keep their requests.

Decomposition:
- Package int_pkg: state encoding (IDLE=2'd0, SERVE=2'd1, FIN=2'd2), MCAUSE_INT_BIT=31, CAUSE_W=5.
- Sub-module int_prio_enc: combinational N_SRC-wide lowest-index priority encoder, outputs index and a valid flag.
- FSM and registers live in the top level.

Test Plan:
- Reset: drive reset=0 with int_req_i=all ones -> int_o=0, mcause_o=0, int_fin_o=0 without any clock edge. Release reset -> int_o=1 one cycle later, mcause_o=32'h8000_0010.
- Single source: mie_i=16'h0008, int_req_i=16'h0008 -> next cycle int_o=1, mcause_o=32'h8000_0013. Pulse int_rst_i -> next cycle int_fin_o=16'h0008 for exactly 1 cycle, int_o=0.
- Priority: int_req_i=16'h0024, mie_i=16'hFFFF -> first serve mcause 32'h8000_0012 (int_fin 16'h0004). After FIN, serve 32'h8000_0015 (int_fin 16'h0020) starting in the first IDLE cycle.
- Masking and mid-serve changes: req=16'h0001, mie=0 -> int_o stays 0 for 20 cycles. Set mie=1 -> int_o next cycle. Then drop req and mie during SERVE -> int_o held until int_rst_i, and fin still goes to bit 0.
- Keyboard loopback: bit 0 wired to keyboard kb_int_o and int_fin_o[0] to kb_int_rst_i; core model pulses int_rst_i 5 cycles after int_o -> kb_int_o falls the edge after fin, no spurious second int_o while FIN, and the keyboard interrupt re-raises later.
- Reset mid-operation: assert reset in SERVE and in FIN -> int_o and int_fin_o go to 0 asynchronously, and no fin pulse appears after release. A still-pending request is re-served.
